mac_frame_collector: RTL
========================

MAC_FRAME_COLLECTOR -- requirements
Module: mac_frame_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 64: receive word width in bits, 8 byte lanes.
REQ-002 Parameter CTRL_WIDTH, default 8: one control bit per byte lane.
REQ-003 Parameter MAX_FRAME_SIZE, default 1518: capture buffer size in bytes.
REQ-004 Parameters START_CODE 8'hFB, TERM_CODE 8'hFD: start and terminate control characters.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port i_rx_data, input, DATA_WIDTH: lane k is bits [8k+7:8k]; lane 0 is first on the wire.
REQ-008 Port i_rx_ctrl, input, CTRL_WIDTH: bit k=1 marks lane k as a control character.
REQ-009 Port i_rx_valid, input, 1: word qualifier; a word with i_rx_valid=0 is ignored, with no state change.
REQ-010 Port o_rx_array_data, output, MAX_FRAME_SIZE*8: captured frame; byte n at bits [8n+7:8n]; byte 0 = START_CODE.
REQ-011 Port o_data_valid, output, 1: one-cycle pulse when o_rx_array_data holds a complete frame.
REQ-012 Port o_frame_len, output, 11: captured byte count, from START_CODE through TERM_CODE inclusive.
REQ-013 Port o_framing_error, output, 1: one-cycle pulse on an aborted frame (unexpected control character).
REQ-014 Port o_overflow_error, output, 1: one-cycle pulse when a frame exceeds MAX_FRAME_SIZE bytes.
REQ-015 Port o_frame_count, output, 32: count of frames delivered; wraps from 2^32-1 to 0.

Function
REQ-016 FSM states: IDLE and COLLECT; a byte counter byte_cnt (11 bits) tracks the write position.
REQ-017 IDLE: a valid word is a start word when ctrl[0]=1, data lane 0=START_CODE and ctrl[7:1]=0.
REQ-018 IDLE accepting a start word: clear the whole buffer to 0, write lanes 0..7 to bytes 0..7, set byte_cnt=8, go to COLLECT.
REQ-019 IDLE: every other word (idle characters, stray data, start with ctrl[7:1]!=0) is discarded silently.
REQ-020 COLLECT, valid word with ctrl=0: write 8 bytes at byte_cnt..byte_cnt+7, then byte_cnt += 8.
REQ-021 COLLECT, lowest control lane L holds TERM_CODE: write lanes 0..L, then byte_cnt += L+1, go to IDLE.
REQ-021a The term event registers o_data_valid=1 and o_frame_len=new byte_cnt, visible the cycle after the edge that sampled the term word.
REQ-022 COLLECT, lowest control lane holds any other value, START_CODE included: abort the frame, pulse o_framing_error next cycle, go to IDLE.
REQ-022a The aborting word is not re-evaluated as a start word.
REQ-023 COLLECT: if a write would place any byte at index >= MAX_FRAME_SIZE, do not write it; pulse o_overflow_error next cycle and go to IDLE.
REQ-023a After an overflow, bytes up to the terminator are discarded as IDLE traffic.
REQ-024 Lanes after the term lane in the same word are ignored.
REQ-024a A start in the next valid word is accepted normally (back-to-back frames).
REQ-025 o_rx_array_data is registered and stays stable from the delivery edge until the next accepted start word.
REQ-025a o_rx_array_data is therefore stable for the full o_data_valid cycle.
REQ-026 o_frame_count increments on the same edge that sets o_data_valid.
REQ-026a o_frame_count does not change on framing or overflow aborts.
REQ-027 o_data_valid, o_framing_error and o_overflow_error are mutually exclusive.
REQ-027a Each of the three pulses is high for exactly one cycle per event.
REQ-028 Collection adds no content checking (preamble, address, FCS); the downstream checker owns those checks.

Reset
REQ-029 While i_rst_n=0: state=IDLE, byte_cnt=0, buffer and o_rx_array_data=0, o_frame_len=0, o_frame_count=0, all pulse outputs=0.
REQ-030 Reset asserted mid-frame discards the partial frame.
REQ-030a After release, the first delivered frame requires a fresh start word.

Verification
REQ-031 Start word FB,55x6,D5, then 64-byte DA..FCS body, then word with FD in lane 0 -> one o_data_valid, o_frame_len=73, byte 72=FD, o_frame_count=1.
REQ-032 Same frame with i_rx_valid=0 for 3 cycles mid-body -> identical array and length to REQ-031.
REQ-033 FD in lane 5 of the final word, then a new start word on the next cycle -> two o_data_valid pulses; bytes after the first FD are 0 at the first pulse.
REQ-034 Ctrl byte FE in lane 3 mid-frame -> o_framing_error one pulse, no o_data_valid, o_frame_count unchanged.
REQ-035 1600 data bytes without FD -> o_overflow_error once, when byte index 1518 would be written; later FD ignored; next frame delivered normally.
REQ-036 i_rst_n pulsed low mid-frame, then a full frame -> outputs 0 during reset; only the second frame is delivered, with o_frame_count=1.

Source files
------------

// File: rtl/mac_frame_collector_if.sv
// mac_frame_collector_if: receive word bus feeding the frame collector.
// One word per cycle, qualified by i_rx_valid; lane 0 is first on the wire.
interface mac_frame_collector_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [CTRL_WIDTH-1:0] i_rx_ctrl;
    logic                  i_rx_valid;

    modport master (
        output i_rx_data,
        output i_rx_ctrl,
        output i_rx_valid
    );

    modport slave (
        input i_rx_data,
        input i_rx_ctrl,
        input i_rx_valid
    );
endinterface

// File: rtl/mac_frame_collector.sv
// mac_frame_collector: gathers one MAC frame from start to terminate
// character into a flat byte buffer and reports delivery or abort.
module mac_frame_collector #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CTRL_WIDTH     = 8,
    parameter int         MAX_FRAME_SIZE = 1518,
    parameter logic [7:0] START_CODE     = 8'hFB,
    parameter logic [7:0] TERM_CODE      = 8'hFD
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    mac_frame_collector_if.slave        rx,
    output logic [MAX_FRAME_SIZE*8-1:0] o_rx_array_data,
    output logic                        o_data_valid,
    output logic [10:0]                 o_frame_len,
    output logic                        o_framing_error,
    output logic                        o_overflow_error,
    output logic [31:0]                 o_frame_count
);
    localparam int LANES = CTRL_WIDTH;
    localparam int IW    = $clog2(MAX_FRAME_SIZE * 8);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [10:0] byte_cnt_q;

    logic        ctl_any;
    logic [3:0]  lo_lane;
    logic [7:0]  lo_char;
    logic [3:0]  wr_n;
    logic [11:0] end_idx;

    logic        start_acc;
    logic        wr_en;
    logic        deliver_d;
    logic        ferr_d;
    logic        oerr_d;

    // Find the lowest control lane of the word and its character
    always_comb begin
        ctl_any = 1'b0;
        lo_lane = '0;
        lo_char = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (rx.i_rx_ctrl[k]) begin
                ctl_any = 1'b1;
                lo_lane = 4'(k);
                lo_char = rx.i_rx_data[8*k +: 8];
            end
        end
    end

    // Bytes this word contributes: all lanes, or up to the terminator
    assign wr_n    = ctl_any ? (lo_lane + 4'd1) : 4'(LANES);
    assign end_idx = {1'b0, byte_cnt_q} + {8'd0, wr_n};

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-word event decode
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        wr_en     = 1'b0;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
        oerr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx.i_rx_valid &&
                    rx.i_rx_ctrl == CTRL_WIDTH'(1) &&
                    rx.i_rx_data[7:0] == START_CODE) begin
                    start_acc = 1'b1;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (rx.i_rx_valid) begin
                    if (ctl_any && lo_char != TERM_CODE) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (end_idx > 12'(MAX_FRAME_SIZE)) begin
                        oerr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        if (ctl_any) begin
                            deliver_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame buffer, write position and registered status outputs
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_array_data  <= '0;
            byte_cnt_q       <= '0;
            o_data_valid     <= 1'b0;
            o_framing_error  <= 1'b0;
            o_overflow_error <= 1'b0;
            o_frame_len      <= '0;
            o_frame_count    <= '0;
        end else begin
            o_data_valid     <= deliver_d;
            o_framing_error  <= ferr_d;
            o_overflow_error <= oerr_d;
            if (start_acc) begin
                o_rx_array_data                   <= '0;
                o_rx_array_data[DATA_WIDTH-1:0]   <= rx.i_rx_data;
                byte_cnt_q                        <= 11'(LANES);
            end else if (wr_en) begin
                for (int k = 0; k < LANES; k++) begin
                    if (4'(k) < wr_n) begin
                        o_rx_array_data[IW'((int'(byte_cnt_q) + k) * 8) +: 8]
                            <= rx.i_rx_data[8*k +: 8];
                    end
                end
                byte_cnt_q <= end_idx[10:0];
            end
            if (deliver_d) begin
                o_frame_len   <= end_idx[10:0];
                o_frame_count <= o_frame_count + 32'd1;
            end
        end
    end
endmodule
